// File: rtl/alu_op_sequencer_if.sv
// Instruction, ALU and result bundle between the sequencer and its surroundings.
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1; valid never waits for ready, and the offering side holds its
// payload stable until the transfer edge.
interface alu_op_sequencer_if;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] aluInput1;
    logic [31:0] aluInput2;
    logic [3:0]  aluControlOut;
    logic [4:0]  shumt;
    logic [31:0] aluResult;
    logic        aluOverflow;
    logic        resValid;
    logic        resReady;
    logic [31:0] resData;
    logic [4:0]  resDest;
    logic        resOverflow;
    logic        resIllegal;
    logic [15:0] opCount;

    // Sequencer side
    modport slave (
        input  instrValid, instr, rsData, rtData, aluResult, aluOverflow, resReady,
        output instrReady, aluInput1, aluInput2, aluControlOut, shumt,
               resValid, resData, resDest, resOverflow, resIllegal, opCount
    );

    // Instruction source, ALU and result sink side
    modport master (
        output instrValid, instr, rsData, rtData, aluResult, aluOverflow, resReady,
        input  instrReady, aluInput1, aluInput2, aluControlOut, shumt,
               resValid, resData, resDest, resOverflow, resIllegal, opCount
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Decodes one instruction at a time, presents operands to an external
// combinational ALU for one cycle, and returns the result through a
// valid/ready response port. Illegal instructions skip the ALU cycle.
module alu_op_sequencer (
    input  logic                   clock,
    input  logic                   resetN,
    alu_op_sequencer_if.slave      bus,
    output logic [1:0]             state_dbg
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [31:0] alu_in1_q,  alu_in1_d;
    logic [31:0] alu_in2_q,  alu_in2_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [4:0]  shamt_q,    shamt_d;
    logic [4:0]  res_dest_q, res_dest_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_ovf_q,  res_ovf_d;
    logic        res_ill_q,  res_ill_d;
    logic [15:0] op_count_q, op_count_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        dec_r_type;
    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_in2;
    logic [4:0]  dec_shamt;
    logic [4:0]  dec_dest;
    logic        instr_ready;
    logic        accept;

    assign opcode     = bus.instr[31:26];
    assign funct      = bus.instr[5:0];
    assign dec_r_type = (opcode == 6'h00);

    // Instruction decode: ALU code, second operand, shift amount and destination
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = 4'd0;
        if (dec_r_type) begin
            dec_legal = 1'b1;
            case (funct)
                6'h20:   dec_ctrl = 4'd0;
                6'h22:   dec_ctrl = 4'd1;
                6'h24:   dec_ctrl = 4'd2;
                6'h25:   dec_ctrl = 4'd3;
                6'h00:   dec_ctrl = 4'd4;
                6'h02:   dec_ctrl = 4'd5;
                6'h03:   dec_ctrl = 4'd6;
                6'h2B:   dec_ctrl = 4'd7;
                6'h2A:   dec_ctrl = 4'd8;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            dec_legal = 1'b1;
            case (opcode)
                6'h08:   dec_ctrl = 4'd0;
                6'h0C:   dec_ctrl = 4'd2;
                6'h0A:   dec_ctrl = 4'd8;
                default: dec_legal = 1'b0;
            endcase
        end

        if (dec_r_type) begin
            dec_in2   = bus.rtData;
            dec_shamt = bus.instr[10:6];
            dec_dest  = bus.instr[15:11];
        end else begin
            // andi zero-extends its immediate; addi and slti sign-extend
            if (opcode == 6'h0C) begin
                dec_in2 = {16'h0000, bus.instr[15:0]};
            end else begin
                dec_in2 = {{16{bus.instr[15]}}, bus.instr[15:0]};
            end
            dec_shamt = 5'd0;
            dec_dest  = bus.instr[20:16];
        end
    end

    // Ready is forced low while reset is asserted, even though the state is IDLE
    assign instr_ready = resetN & ((state_q == IDLE) | ((state_q == RESP) & bus.resReady));
    assign accept      = bus.instrValid & instr_ready;

    // Next-state logic: ALU result capture, response completion and new accepts
    always_comb begin
        state_d    = state_q;
        alu_in1_d  = alu_in1_q;
        alu_in2_d  = alu_in2_q;
        alu_ctrl_d = alu_ctrl_q;
        shamt_d    = shamt_q;
        res_dest_d = res_dest_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        res_ill_d  = res_ill_q;
        op_count_d = op_count_q;

        case (state_q)
            EXEC: begin
                state_d    = RESP;
                res_data_d = bus.aluResult;
                // Overflow is only meaningful for add and sub
                res_ovf_d  = bus.aluOverflow & ((alu_ctrl_q == 4'd0) | (alu_ctrl_q == 4'd1));
                res_ill_d  = 1'b0;
            end
            RESP: begin
                if (bus.resReady) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: ;
        endcase

        // An accept (from IDLE or from a completing RESP) overrides the above
        if (accept) begin
            alu_in1_d  = bus.rsData;
            alu_in2_d  = dec_in2;
            shamt_d    = dec_shamt;
            res_dest_d = dec_dest;
            if (dec_legal) begin
                alu_ctrl_d = dec_ctrl;
                state_d    = EXEC;
            end else begin
                // Illegal: respond immediately, leave the ALU op code untouched
                state_d    = RESP;
                res_data_d = 32'd0;
                res_ovf_d  = 1'b0;
                res_ill_d  = 1'b1;
            end
        end
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            alu_in1_q  <= 32'd0;
            alu_in2_q  <= 32'd0;
            alu_ctrl_q <= 4'd0;
            shamt_q    <= 5'd0;
            res_dest_q <= 5'd0;
            res_data_q <= 32'd0;
            res_ovf_q  <= 1'b0;
            res_ill_q  <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            alu_in1_q  <= alu_in1_d;
            alu_in2_q  <= alu_in2_d;
            alu_ctrl_q <= alu_ctrl_d;
            shamt_q    <= shamt_d;
            res_dest_q <= res_dest_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
            res_ill_q  <= res_ill_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.instrReady    = instr_ready;
    assign bus.aluInput1     = alu_in1_q;
    assign bus.aluInput2     = alu_in2_q;
    assign bus.aluControlOut = alu_ctrl_q;
    assign bus.shumt         = shamt_q;
    assign bus.resValid      = (state_q == RESP);
    assign bus.resData       = res_data_q;
    assign bus.resDest       = res_dest_q;
    assign bus.resOverflow   = res_ovf_q;
    assign bus.resIllegal    = res_ill_q;
    assign bus.opCount       = op_count_q;
    assign state_dbg         = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;
    logic       clock;
    logic       resetN;
    logic       force_ovf;
    logic [1:0] state_dbg;

    int vectors;
    int miscompares;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clock     (clock),
        .resetN    (resetN),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU; force_ovf raises overflow regardless of op
    logic signed [31:0] alu_a, alu_b, alu_r;
    logic               alu_v;
    always_comb begin
        alu_a = $signed(bus.aluInput1);
        alu_b = $signed(bus.aluInput2);
        alu_r = 32'sd0;
        alu_v = 1'b0;
        case (bus.aluControlOut)
            4'd0: begin
                alu_r = alu_a + alu_b;
                alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'd1: begin
                alu_r = alu_a - alu_b;
                alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'd2: alu_r = alu_a & alu_b;
            4'd3: alu_r = alu_a | alu_b;
            4'd4: alu_r = alu_b << bus.shumt;
            4'd5: alu_r = alu_b >> bus.shumt;
            4'd6: alu_r = alu_b >>> bus.shumt;
            4'd7: alu_r = (alu_a > alu_b) ? 32'sd1 : 32'sd0;
            4'd8: alu_r = (alu_a < alu_b) ? 32'sd1 : 32'sd0;
            default: alu_r = 32'sd0;
        endcase
        bus.aluResult   = alu_r;
        bus.aluOverflow = alu_v | force_ovf;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One legal instruction end to end with resReady held high
    task automatic run_legal(input string tag, input logic [31:0] ins,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] exp_in1, input logic [31:0] exp_in2,
                             input logic [3:0] exp_ctrl, input logic [4:0] exp_sh,
                             input logic [31:0] exp_data, input logic [4:0] exp_dest,
                             input logic exp_ovf, input logic [15:0] exp_cnt);
        bus.instr      = ins;
        bus.rsData     = rs;
        bus.rtData     = rt;
        bus.instrValid = 1'b1;
        bus.resReady   = 1'b1;
        tick();
        bus.instrValid = 1'b0;
        chk({tag, "_state_exec"}, 32'(state_dbg), 32'd1);
        chk({tag, "_in1"}, bus.aluInput1, exp_in1);
        chk({tag, "_in2"}, bus.aluInput2, exp_in2);
        chk({tag, "_ctrl"}, 32'(bus.aluControlOut), 32'(exp_ctrl));
        chk({tag, "_shumt"}, 32'(bus.shumt), 32'(exp_sh));
        chk({tag, "_valid_lo"}, 32'(bus.resValid), 32'd0);
        tick();
        chk({tag, "_valid_hi"}, 32'(bus.resValid), 32'd1);
        chk({tag, "_data"}, bus.resData, exp_data);
        chk({tag, "_dest"}, 32'(bus.resDest), 32'(exp_dest));
        chk({tag, "_ovf"}, 32'(bus.resOverflow), 32'(exp_ovf));
        chk({tag, "_ill"}, 32'(bus.resIllegal), 32'd0);
        tick();
        chk({tag, "_done_valid"}, 32'(bus.resValid), 32'd0);
        chk({tag, "_count"}, 32'(bus.opCount), 32'(exp_cnt));
        chk({tag, "_idle"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        force_ovf      = 1'b0;
        resetN         = 1'b1;
        bus.instrValid = 1'b0;
        bus.instr      = 32'd0;
        bus.rsData     = 32'd0;
        bus.rtData     = 32'd0;
        bus.resReady   = 1'b0;

        // Reset values
        #2 resetN = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.instrReady), 32'd0);
        chk("rst_valid", 32'(bus.resValid), 32'd0);
        chk("rst_ctrl", 32'(bus.aluControlOut), 32'd0);
        chk("rst_count", 32'(bus.opCount), 32'd0);
        chk("rst_in1", bus.aluInput1, 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        tick();
        tick();
        resetN = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.instrReady), 32'd1);

        // Legal instruction mix
        run_legal("addi", {6'h08, 5'd1, 5'd7, 16'hFFFD}, 32'd5, 32'd0,
                  32'd5, 32'hFFFFFFFD, 4'd0, 5'd0, 32'd2, 5'd7, 1'b0, 16'd1);
        run_legal("add_ovf", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h7FFFFFFF, 32'd1,
                  32'h7FFFFFFF, 32'd1, 4'd0, 5'd0, 32'h80000000, 5'd3, 1'b1, 16'd2);
        force_ovf = 1'b1;
        run_legal("or_mask", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 32'h7FFFFFFF, 32'd1,
                  32'h7FFFFFFF, 32'd1, 4'd3, 5'd0, 32'h7FFFFFFF, 5'd3, 1'b0, 16'd3);
        force_ovf = 1'b0;
        run_legal("sra", {6'h00, 5'd4, 5'd5, 5'd6, 5'd4, 6'h03}, 32'd0, 32'h80000010,
                  32'd0, 32'h80000010, 4'd6, 5'd4, 32'hF8000001, 5'd6, 1'b0, 16'd4);
        run_legal("slti", {6'h0A, 5'd1, 5'd8, 16'hFFFE}, 32'hFFFFFFFD, 32'd0,
                  32'hFFFFFFFD, 32'hFFFFFFFE, 4'd8, 5'd0, 32'd1, 5'd8, 1'b0, 16'd5);
        run_legal("andi", {6'h0C, 5'd1, 5'd9, 16'h8F0F}, 32'hFFFF1234, 32'd0,
                  32'hFFFF1234, 32'h00008F0F, 4'd2, 5'd0, 32'h00000204, 5'd9, 1'b0, 16'd6);
        run_legal("sgt_rd0", {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h2B}, 32'd1, 32'hFFFFFFFF,
                  32'd1, 32'hFFFFFFFF, 4'd7, 5'd0, 32'd1, 5'd0, 1'b0, 16'd7);
        run_legal("sub_ovf", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 32'h80000000, 32'd1,
                  32'h80000000, 32'd1, 4'd1, 5'd0, 32'h7FFFFFFF, 5'd3, 1'b1, 16'd8);

        // Illegal opcode, then back-pressure with a new instruction waiting
        bus.instr      = {6'h3F, 5'd1, 5'd9, 16'h0000};
        bus.instrValid = 1'b1;
        bus.resReady   = 1'b0;
        tick();
        bus.instr  = {6'h08, 5'd2, 5'd4, 16'h0003};
        bus.rsData = 32'd10;
        chk("ill_valid", 32'(bus.resValid), 32'd1);
        chk("ill_flag", 32'(bus.resIllegal), 32'd1);
        chk("ill_data", bus.resData, 32'd0);
        chk("ill_dest", 32'(bus.resDest), 32'd9);
        chk("ill_ovf", 32'(bus.resOverflow), 32'd0);
        chk("ill_ctrl_kept", 32'(bus.aluControlOut), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", 32'(bus.instrReady), 32'd0);
            chk("bp_valid", 32'(bus.resValid), 32'd1);
            chk("bp_ill", 32'(bus.resIllegal), 32'd1);
            chk("bp_dest", 32'(bus.resDest), 32'd9);
            chk("bp_count", 32'(bus.opCount), 32'd8);
        end
        bus.resReady = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.instrReady), 32'd1);
        tick();
        bus.instrValid = 1'b0;
        chk("overlap_count", 32'(bus.opCount), 32'd9);
        chk("overlap_state", 32'(state_dbg), 32'd1);
        chk("overlap_ctrl", 32'(bus.aluControlOut), 32'd0);
        chk("overlap_in2", bus.aluInput2, 32'd3);
        tick();
        chk("overlap_res_valid", 32'(bus.resValid), 32'd1);
        chk("overlap_res_data", bus.resData, 32'd13);
        chk("overlap_res_dest", 32'(bus.resDest), 32'd4);
        tick();
        chk("overlap_done_count", 32'(bus.opCount), 32'd10);

        // Reset in the middle of EXEC
        bus.instr      = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22};
        bus.rsData     = 32'd2;
        bus.rtData     = 32'd3;
        bus.instrValid = 1'b1;
        tick();
        bus.instrValid = 1'b0;
        chk("mid_exec_state", 32'(state_dbg), 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.instrReady), 32'd0);
        chk("mid_rst_valid", 32'(bus.resValid), 32'd0);
        chk("mid_rst_ctrl", 32'(bus.aluControlOut), 32'd0);
        chk("mid_rst_in1", bus.aluInput1, 32'd0);
        chk("mid_rst_count", 32'(bus.opCount), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("after_rst_valid", 32'(bus.resValid), 32'd0);
        end
        chk("after_rst_count", 32'(bus.opCount), 32'd0);
        chk("after_rst_ready", 32'(bus.instrReady), 32'd1);

        // Counter wrap through a back-to-back stream of illegal instructions
        bus.instr      = {6'h3F, 5'd0, 5'd1, 16'h0000};
        bus.instrValid = 1'b1;
        bus.resReady   = 1'b1;
        repeat (65536) tick();
        chk("wrap_pre_count", 32'(bus.opCount), 32'h0000FFFF);
        chk("wrap_pre_valid", 32'(bus.resValid), 32'd1);
        bus.instrValid = 1'b0;
        tick();
        chk("wrap_count", 32'(bus.opCount), 32'd0);
        chk("wrap_valid", 32'(bus.resValid), 32'd0);
        chk("wrap_state", 32'(state_dbg), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 resetN  input  1  asynchronous, active-low reset.
REQ-003 instrValid  input  1  instruction offer; instrReady  output  1  sequencer can accept.
REQ-004 instr  input  32  instruction word (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0]).
REQ-005 rsData, rtData  input  32 each  signed operand values accompanying instr.
REQ-006 aluInput1, aluInput2  output  32  signed ALU operands; aluControlOut  output  4  ALU op code; shumt  output  5  shift amount.
REQ-007 aluResult  input  32  ALU result; aluOverflow  input  1  ALU overflow flag (combinational response to the above).
REQ-008 resValid  output  1; resReady  input  1  result handshake.
REQ-009 resData  output  32; resDest  output  5; resOverflow  output  1; resIllegal  output  1  result fields.
REQ-010 opCount  output  16  completed-response counter.

Function
REQ-011 Decode, opcode 0: funct 0x20->0 add, 0x22->1 sub, 0x24->2 and, 0x25->3 or, 0x00->4 sll, 0x02->5 srl, 0x03->6 sra, 0x2B->7 sgt, 0x2A->8 slt.
REQ-012 Decode, I-type: opcode 0x08 addi->0, 0x0C andi->2, 0x0A slti->8; any other opcode/funct is illegal.
REQ-013 R-type: aluInput1=rsData, aluInput2=rtData, shumt=shamt, resDest=rd.
REQ-014 I-type: aluInput1=rsData, aluInput2=imm sign-extended (addi, slti) or zero-extended (andi), shumt=0, resDest=rt.
REQ-015 States: IDLE, EXEC, RESP.
REQ-016 instrReady = 1 in IDLE, or in RESP while resReady=1; 0 otherwise.
REQ-017 Accept = instrValid & instrReady at an edge; at that edge aluInput1/2, aluControlOut, shumt, resDest are registered.
REQ-018 Legal accept -> EXEC; ALU outputs held stable for the whole EXEC cycle.
REQ-019 EXEC -> RESP at next edge, capturing resData=aluResult, resOverflow=aluOverflow for codes 0/1, else 0; resIllegal=0.
REQ-020 Illegal accept -> RESP directly at the accept edge+0 path: next state RESP, resData=0, resOverflow=0, resIllegal=1, resDest=decoded field, aluControlOut unchanged.
REQ-021 Latency: legal accept edge to resValid=1 is 2 edges; illegal is 1 edge.
REQ-022 resValid=1 only in RESP; resData/resDest/resOverflow/resIllegal stable while resValid=1 and resReady=0.
REQ-023 RESP with resReady=1: response completes; opCount increments; next state EXEC/RESP if a new instruction is accepted same edge, else IDLE.
REQ-024 Simultaneous completion and accept: new instruction's registers load; old response fields stay valid until that edge only.
REQ-025 opCount wraps 0xFFFF -> 0x0000 without flag.
REQ-026 resDest=0 is not special: response produced normally.
REQ-027 instrValid may drop without acceptance; no state change in that case.

Reset
REQ-028 resetN=0 forces, asynchronously: state IDLE, all outputs 0 (including instrReady, resValid, aluControlOut, opCount).
REQ-029 instrReady rises in the first cycle after resetN deasserts.
REQ-030 Reset during EXEC or RESP discards the in-flight operation; no response is produced and opCount is not incremented.

Verification
REQ-031 addi, rsData=5, imm=0xFFFD, resReady=1 -> aluInput2=0xFFFFFFFD, aluControlOut=0, 2 edges later resValid=1, resData=2, resDest=rt, opCount=1.
REQ-032 add, rsData=0x7FFFFFFF, rtData=1 with ALU overflow=1 -> resData=0x80000000, resOverflow=1; same operands via or (code 3) -> resOverflow=0.
REQ-033 Illegal opcode 0x3F -> resValid after 1 edge, resIllegal=1, resData=0, opCount increments on handshake.
REQ-034 resReady held 0 for 5 cycles in RESP -> instrReady=0, response fields unchanged; resReady=1 with instrValid=1 -> completion and accept on same edge.
REQ-035 resetN pulsed low mid-EXEC -> all outputs 0 immediately, no response after release, opCount=0.
REQ-036 opCount preset to 0xFFFF via 65535 completions, one more -> opCount=0x0000.
